// File: rtl/tm_channel_scheduler.sv
// Output-channel scheduler: issues per-channel weight reads per window, tags them through the
// fixed-latency compute pipe and steers scaled results into per-channel buffers. Option: TCS_PERF_COUNTER_EN.
module tm_channel_scheduler #(
  parameter int unsigned TM            = 16,
  parameter int unsigned TN            = 4,
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned WADDR_WIDTH   = 16,
  parameter int unsigned OADDR_WIDTH   = 10,
  parameter int unsigned PIPE_LAT      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     config_enable,
  input  logic                     config_clear,
  input  logic [7:0]               com_type,
  input  logic [WADDR_WIDTH-1:0]   weight_base,
  input  logic [OADDR_WIDTH-1:0]   pix_count,
  input  logic                     feature_ready,
  output logic [WADDR_WIDTH-1:0]   weight_addr,
  output logic                     weight_read_en,
  output logic                     scaler_rd_en,
  input  logic                     scaled_valid_in,
  input  logic [FEATURE_WIDTH-1:0] scaled_data_in,
  output logic [TM-1:0]            buf_wr_en,
  output logic [OADDR_WIDTH-1:0]   buf_wr_addr,
  output logic [FEATURE_WIDTH-1:0] buf_wr_data,
  output logic                     busy,
  output logic                     tile_done,
  output logic                     err_overlap
`ifdef TCS_PERF_COUNTER_EN
  ,
  output logic [31:0]              perf_busy_cycles
`endif
);

  localparam int unsigned CH_W  = (TM > 1) ? $clog2(TM) : 1;
  localparam int unsigned CNT_W = $clog2(TM + 1);
  localparam logic [7:0]  MODE_CONV   = 8'h01;
  localparam logic [7:0]  MODE_DWCONV = 8'h02;
  localparam logic [7:0]  MODE_PWCONV = 8'h04;
  // Tag pipe stages other than the tail; all clear means the tail holds the last outstanding read.
  localparam logic [PIPE_LAT-1:0] HEAD_MASK = {PIPE_LAT{1'b1}} >> 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [7:0]               mode_q;
  logic [WADDR_WIDTH-1:0]   base_q;
  logic [OADDR_WIDTH-1:0]   pix_q;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [OADDR_WIDTH-1:0]   win_q, win_d;
  logic                     pend_q, pend_d;

  logic [CNT_W-1:0]         nch_c;
  logic                     mode_ok_c, last_ch_c, last_win_c, drain_done_c, fr_err_c;

  logic [PIPE_LAT-1:0]                  pipe_v_q;
  logic [PIPE_LAT-1:0][CH_W-1:0]        pipe_ch_q;
  logic [PIPE_LAT-1:0][OADDR_WIDTH-1:0] pipe_win_q;
  logic                                 tail_v_c, tail_wr_c;

  logic                     rd_en_q, rd_en_d;
  logic [WADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CH_W-1:0]          rd_ch_q, rd_ch_d;
  logic [OADDR_WIDTH-1:0]   rd_win_q, rd_win_d;
  logic [TM-1:0]            wr_en_q, wr_en_d;
  logic [OADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [FEATURE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Channel count for the latched mode
  always_comb begin
    nch_c     = '0;
    mode_ok_c = 1'b1;
    case (mode_q)
      MODE_CONV, MODE_PWCONV: nch_c = CNT_W'(TM);
      MODE_DWCONV:            nch_c = CNT_W'(TN);
      default:                mode_ok_c = 1'b0;
    endcase
  end

  assign last_ch_c    = (CNT_W'(ch_q) == nch_c - CNT_W'(1));
  assign last_win_c   = (win_q == pix_q - OADDR_WIDTH'(1));
  assign drain_done_c = ~|(pipe_v_q & HEAD_MASK) & ~rd_en_q;
  assign tail_v_c     = pipe_v_q[PIPE_LAT-1];
  assign tail_wr_c    = tail_v_c & scaled_valid_in;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    win_d    = win_q;
    pend_d   = pend_q;
    fr_err_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (feature_ready && mode_ok_c) begin
          state_d = ST_ISSUE;
          ch_d    = '0;
          win_d   = '0;
          pend_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (last_ch_c) begin
          if (feature_ready && pend_q) fr_err_c = 1'b1;
          if (last_win_c) begin
            state_d = ST_DRAIN;
            pend_d  = 1'b0;
          end else if (pend_q || feature_ready) begin
            ch_d   = '0;
            win_d  = win_q + OADDR_WIDTH'(1);
            pend_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          ch_d = ch_q + CH_W'(1);
          if (feature_ready) begin
            if (pend_q) fr_err_c = 1'b1;
            else        pend_d   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (feature_ready) begin
          state_d = ST_ISSUE;
          ch_d    = '0;
          win_d   = win_q + OADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (feature_ready) fr_err_c = 1'b1;
        if (drain_done_c)  state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so the first read follows feature_ready by one cycle
  always_comb begin
    rd_en_d   = (state_d == ST_ISSUE);
    addr_d    = '0;
    rd_ch_d   = '0;
    rd_win_d  = '0;
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    if (rd_en_d) begin
      rd_ch_d  = ch_d;
      rd_win_d = win_d;
      if (mode_q == MODE_PWCONV) addr_d = base_q + WADDR_WIDTH'(ch_d);
      else addr_d = base_q + WADDR_WIDTH'(win_d) * WADDR_WIDTH'(nch_c) + WADDR_WIDTH'(ch_d);
    end
    if (tail_wr_c) begin
      wr_en_d   = TM'(1) << pipe_ch_q[PIPE_LAT-1];
      wr_addr_d = pipe_win_q[PIPE_LAT-1];
      wr_data_d = scaled_data_in;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DRAIN) && drain_done_c;
    err_d  = config_enable ? 1'b0 : (err_q | fr_err_c | (tail_v_c != scaled_valid_in));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      base_q     <= '0;
      pix_q      <= '0;
      ch_q       <= '0;
      win_q      <= '0;
      pend_q     <= 1'b0;
      pipe_v_q   <= '0;
      pipe_ch_q  <= '0;
      pipe_win_q <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      rd_ch_q    <= '0;
      rd_win_q   <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      win_q     <= win_d;
      pend_q    <= pend_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      rd_ch_q   <= rd_ch_d;
      rd_win_q  <= rd_win_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      // Configuration only changes between tiles
      if (state_q == ST_IDLE) begin
        if (config_enable) begin
          mode_q <= com_type;
          base_q <= weight_base;
          pix_q  <= pix_count;
        end else if (config_clear) begin
          mode_q <= '0;
        end
      end
      pipe_v_q[0]   <= rd_en_q;
      pipe_ch_q[0]  <= rd_ch_q;
      pipe_win_q[0] <= rd_win_q;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_ch_q[i]  <= pipe_ch_q[i-1];
        pipe_win_q[i] <= pipe_win_q[i-1];
      end
    end
  end

  generate
    if (PIPE_LAT > 1) begin : g_srd_pipe
      assign scaler_rd_en = pipe_v_q[PIPE_LAT-2];
    end else begin : g_srd_direct
      assign scaler_rd_en = rd_en_q;
    end
  endgenerate

  assign weight_addr    = addr_q;
  assign weight_read_en = rd_en_q;
  assign buf_wr_en      = wr_en_q;
  assign buf_wr_addr    = wr_addr_q;
  assign buf_wr_data    = wr_data_q;
  assign busy           = busy_q;
  assign tile_done      = done_q;
  assign err_overlap    = err_q;

`ifdef TCS_PERF_COUNTER_EN
  logic [31:0] perf_q;

  // Saturating busy-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           perf_q <= '0;
    else if (config_enable)             perf_q <= '0;
    else if (busy_q && (perf_q != '1))  perf_q <= perf_q + 32'd1;
  end

  assign perf_busy_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tm_channel_scheduler.sv
// Directed bench for tm_channel_scheduler: a delay-line scaler stand-in returns each read address as data.
module tb_tm_channel_scheduler;
  localparam int TM = 16, TN = 4, FW = 16, WW = 16, OW = 10, PL = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic config_enable = 1'b0, config_clear = 1'b0, feature_ready = 1'b0, force_v = 1'b0;
  logic [7:0] com_type = '0;
  logic [WW-1:0] weight_base = '0;
  logic [OW-1:0] pix_count = '0;
  logic [WW-1:0] weight_addr;
  logic weight_read_en, scaler_rd_en, scaled_valid_in, busy, tile_done, err_overlap;
  logic [FW-1:0] scaled_data_in, buf_wr_data;
  logic [TM-1:0] buf_wr_en;
  logic [OW-1:0] buf_wr_addr;
`ifdef TCS_PERF_COUNTER_EN
  logic [31:0] perf_busy_cycles;
`endif

  tm_channel_scheduler #(.TM(TM), .TN(TN), .FEATURE_WIDTH(FW), .WADDR_WIDTH(WW),
                         .OADDR_WIDTH(OW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .config_enable(config_enable), .config_clear(config_clear),
    .com_type(com_type), .weight_base(weight_base), .pix_count(pix_count),
    .feature_ready(feature_ready), .weight_addr(weight_addr), .weight_read_en(weight_read_en),
    .scaler_rd_en(scaler_rd_en), .scaled_valid_in(scaled_valid_in), .scaled_data_in(scaled_data_in),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .busy(busy),
    .tile_done(tile_done), .err_overlap(err_overlap)
`ifdef TCS_PERF_COUNTER_EN
    , .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Scaler stand-in: valid/data arrive exactly PL cycles after each read
  logic [PL-1:0] m_v;
  logic [WW-1:0] m_a [PL];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v <= '0;
      for (int i = 0; i < PL; i++) m_a[i] <= '0;
    end else begin
      m_v <= {m_v[PL-2:0], weight_read_en};
      m_a[0] <= weight_addr;
      for (int i = 1; i < PL; i++) m_a[i] <= m_a[i-1];
    end
  end
  assign scaled_valid_in = m_v[PL-1] | force_v;
  assign scaled_data_in  = m_a[PL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_addr[$], rd_cyc[$], wr_en[$], wr_addr[$], wr_data[$], wr_cyc[$];
  int done_cnt = 0, done_cyc = 0, srd_bad = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (weight_read_en) begin rd_addr.push_back(32'(weight_addr)); rd_cyc.push_back(32'(cyc)); end
      if (buf_wr_en != '0) begin
        wr_en.push_back(32'(buf_wr_en)); wr_addr.push_back(32'(buf_wr_addr));
        wr_data.push_back(32'(buf_wr_data)); wr_cyc.push_back(32'(cyc));
      end
      if (tile_done) begin done_cnt++; done_cyc = cyc; end
      if (scaler_rd_en !== m_v[PL-2]) srd_bad++;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_addr.delete(); rd_cyc.delete(); wr_en.delete(); wr_addr.delete();
    wr_data.delete(); wr_cyc.delete();
    done_cnt = 0; done_cyc = 0; srd_bad = 0;
  endtask

  task automatic cfg(input logic [7:0] ct, input logic [WW-1:0] b, input logic [OW-1:0] p);
    com_type = ct; weight_base = b; pix_count = p; config_enable = 1'b1;
    tick();
    config_enable = 1'b0;
  endtask

  task automatic pulse_fr();
    feature_ready = 1'b1;
    tick();
    feature_ready = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 400) begin tick(); n++; end
    tick(3);
  endtask

  // Expected tile: window w, channel c -> read base + (w*nch or 0) + c; write lane c at pixel w
  task automatic check_tile(input string tag, input int nwin, input int nch,
                            input logic [WW-1:0] base, input bit pw, input logic [31:0] exp_err);
    int n = nwin * nch;
    check({tag, "_nrd"}, 32'(rd_addr.size()), 32'(n));
    check({tag, "_nwr"}, 32'(wr_en.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      int w = i / nch;
      int c = i % nch;
      logic [WW-1:0] ea = base + WW'(pw ? c : w * nch + c);
      if (i < rd_addr.size()) check($sformatf("%s_addr%0d", tag, i), rd_addr[i], 32'(ea));
      if (i < wr_en.size()) begin
        check($sformatf("%s_wen%0d", tag, i), wr_en[i], 32'(1) << c);
        check($sformatf("%s_wad%0d", tag, i), wr_addr[i], 32'(w));
        check($sformatf("%s_wdt%0d", tag, i), wr_data[i], 32'(ea));
      end
    end
    if (rd_cyc.size() == n && n > 0) check({tag, "_contig"}, rd_cyc[n-1] - rd_cyc[0], 32'(n - 1));
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    if (wr_cyc.size() > 0) check({tag, "_done_align"}, 32'(done_cyc), wr_cyc[wr_cyc.size()-1]);
    check({tag, "_err"}, 32'(err_overlap), exp_err);
    check({tag, "_srd"}, 32'(srd_bad), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int fr_cyc;
    tick(3);
    check("rst_rd_en", 32'(weight_read_en), 32'd0);
    check("rst_addr", 32'(weight_addr), 32'd0);
    check("rst_wr_en", 32'(buf_wr_en), 32'd0);
    check("rst_flags", {29'd0, busy, tile_done, err_overlap}, 32'd0);
    rst = 1'b1;
    tick(2);

    // 1: CONV single window
    clear_log();
    cfg(8'h01, 16'h0100, 10'd1);
    fr_cyc = cyc;
    pulse_fr();
    check("t1_busy", 32'(busy), 32'd1);
    wait_done();
    check_tile("t1", 1, TM, 16'h0100, 1'b0, 32'd0);
    if (rd_cyc.size() > 0) check("t1_rd_lat", rd_cyc[0] - 32'(fr_cyc), 32'd1);
    if (rd_cyc.size() > 0 && wr_cyc.size() > 0) check("t1_wr_lat", wr_cyc[0] - rd_cyc[0], 32'(PL + 1));

    // 2: DWCONV, three windows back to back
    clear_log();
    cfg(8'h02, 16'h0200, 10'd3);
    pulse_fr(); tick(3); pulse_fr(); tick(3); pulse_fr();
    wait_done();
    check_tile("t2", 3, TN, 16'h0200, 1'b0, 32'd0);

    // 3: PWCONV, second window requested at ch=5
    clear_log();
    cfg(8'h04, 16'h0300, 10'd2);
    pulse_fr(); tick(5); pulse_fr();
    wait_done();
    check_tile("t3", 2, TM, 16'h0300, 1'b1, 32'd0);

    // 4: third request while one is pending is dropped
    clear_log();
    cfg(8'h04, 16'h0400, 10'd2);
    pulse_fr(); tick(1); pulse_fr(); tick(1); pulse_fr();
    wait_done();
    check_tile("t4", 2, TM, 16'h0400, 1'b1, 32'd1);

    // 6: scaler valid with empty tag pipe
    clear_log();
    cfg(8'h01, 16'h0000, 10'd1);
    check("t6_err_cleared", 32'(err_overlap), 32'd0);
    force_v = 1'b1; tick(); force_v = 1'b0;
    tick(3);
    check("t6_nwr", 32'(wr_en.size()), 32'd0);
    check("t6_err", 32'(err_overlap), 32'd1);

    // 5a: unsupported mode ignores feature_ready
    clear_log();
    cfg(8'h08, 16'h0000, 10'd1);
    pulse_fr(); tick(5);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_nrd", 32'(rd_addr.size()), 32'd0);

    // 5b: config_clear returns to the idle mode
    clear_log();
    cfg(8'h01, 16'h0000, 10'd1);
    config_clear = 1'b1; tick(); config_clear = 1'b0;
    pulse_fr(); tick(5);
    check("t5_clr_nrd", 32'(rd_addr.size()), 32'd0);

    // 5c: reset in the middle of ISSUE
    cfg(8'h01, 16'h0040, 10'd1);
    pulse_fr(); tick(3);
    check("t5_mid_busy", 32'(busy), 32'd1);
    check("t5_mid_rd", 32'(weight_read_en), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_rd", 32'(weight_read_en), 32'd0);
    check("t5_rst_addr", 32'(weight_addr), 32'd0);
    check("t5_rst_srd", 32'(scaler_rd_en), 32'd0);
    check("t5_rst_flags", {29'd0, busy, tile_done, err_overlap}, 32'd0);
    tick(2);
    clear_log();
    rst = 1'b1;
    tick(20);
    check("t5_post_nrd", 32'(rd_addr.size()), 32'd0);
    check("t5_post_nwr", 32'(wr_en.size()), 32'd0);
    check("t5_post_done", 32'(done_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
